// File: rtl/song_reader_if.sv
// Bus between song_reader, the song ROM and note_player: ROM address/data plus
// the note hand-off (load pulse out, done pulse back).
interface song_reader_if #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
);
  logic [SONG_BITS+NOTE_BITS-1:0] rom_addr;
  logic [11:0]                    rom_data;
  logic [5:0]                     note_to_load;
  logic [5:0]                     duration_to_load;
  logic                           load_new_note;
  logic                           note_done;

  modport master (
    output rom_addr, note_to_load, duration_to_load, load_new_note,
    input  rom_data, note_done
  );

  modport slave (
    input  rom_addr, note_to_load, duration_to_load, load_new_note,
    output rom_data, note_done
  );
endinterface

// File: rtl/song_reader.sv
// Walks one song in the synchronous song ROM, handing each {note, duration}
// to note_player and waiting for its done pulse before fetching the next.
module song_reader #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic                 restart,
  input  logic [SONG_BITS-1:0] song,
  output logic                 song_done,
  song_reader_if.master        bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLAYING,
    ST_DONE
  } state_t;

  state_t               state, state_n;
  logic [SONG_BITS-1:0] song_q, song_n;
  logic [NOTE_BITS-1:0] idx, idx_n;
  logic [5:0]           note_q, note_n;
  logic [5:0]           dur_q, dur_n;
  logic                 load_q, load_n;
  logic                 done_q, done_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      song_q <= '0;
      idx    <= '0;
      note_q <= '0;
      dur_q  <= '0;
      load_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      song_q <= song_n;
      idx    <= idx_n;
      note_q <= note_n;
      dur_q  <= dur_n;
      load_q <= load_n;
      done_q <= done_n;
    end
  end

  // Pulses default low so each lasts exactly one cycle; restart overrides all.
  always_comb begin
    state_n = state;
    song_n  = song_q;
    idx_n   = idx;
    note_n  = note_q;
    dur_n   = dur_q;
    load_n  = 1'b0;
    done_n  = 1'b0;

    if (restart) begin
      state_n = ST_IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_n = '0;
          if (play) begin
            song_n  = song;
            state_n = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (play) state_n = ST_WAIT;
        end
        ST_WAIT: begin
          // Address is held while paused, so rom_data stays valid here.
          if (play) begin
            if (bus.rom_data[5:0] == 6'd0) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else begin
              note_n  = bus.rom_data[11:6];
              dur_n   = bus.rom_data[5:0];
              load_n  = 1'b1;
              state_n = ST_PLAYING;
            end
          end
        end
        ST_PLAYING: begin
          if (bus.note_done) begin
            if (idx == '1) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else begin
              idx_n   = idx + 1'b1;
              state_n = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end
      endcase
    end
  end

  assign bus.rom_addr         = {song_q, idx};
  assign bus.note_to_load     = note_q;
  assign bus.duration_to_load = dur_q;
  assign bus.load_new_note    = load_q;
  assign song_done            = done_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: ROM model, expected-note scoreboard popped
// on every load pulse, and cycle-exact checks of addresses and pulses.
module tb_song_reader;
  localparam int SONG_BITS = 2;
  localparam int NOTE_BITS = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       restart;
  logic [1:0] song;
  logic       song_done;

  song_reader_if #(.SONG_BITS(SONG_BITS), .NOTE_BITS(NOTE_BITS)) bus_if ();

  song_reader #(.SONG_BITS(SONG_BITS), .NOTE_BITS(NOTE_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .restart   (restart),
    .song      (song),
    .song_done (song_done),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [128];
  logic [11:0] exp_q [$];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic        prev_load = 1'b0;

  always @(posedge clk) bus_if.rom_data <= rom[bus_if.rom_addr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic r, input logic [1:0] s);
    play    = p;
    restart = r;
    song    = s;
  endtask

  task automatic expectNote(input int s, input int i);
    exp_q.push_back(rom[s*32+i]);
  endtask

  task automatic pulseDone();
    bus_if.note_done = 1'b1;
    @(negedge clk);
    bus_if.note_done = 1'b0;
  endtask

  task automatic waitLoad(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      checkOutput(tag, 32'(bus_if.load_new_note), 32'(i == n));
    end
  endtask

  // Scoreboard: every load must be single-cycle, expected, and match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus_if.load_new_note === 1'b1) begin
      checkOutput("load_single", 32'(prev_load), 0);
      checkOutput("load_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        checkOutput("load_value", 32'({bus_if.note_to_load, bus_if.duration_to_load}),
                    32'(exp_q.pop_front()));
    end
    prev_load = bus_if.load_new_note;
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom[i]      = {6'(i + 3), 6'd5};
      rom[32 + i] = {6'd9, 6'd4};
      rom[64 + i] = {6'(i), 6'(i + 1)};
      rom[96 + i] = {6'(63 - i), 6'(i % 7 + 1)};
    end
    rom[32] = 12'h042;
    rom[33] = {6'd47, 6'd10};
    rom[34] = {6'd12, 6'd0};

    reset = 1'b0;
    bus_if.note_done = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_addr", 32'(bus_if.rom_addr), 0);
    checkOutput("rst_note", 32'(bus_if.note_to_load), 0);
    checkOutput("rst_dur", 32'(bus_if.duration_to_load), 0);
    checkOutput("rst_load", 32'(bus_if.load_new_note), 0);
    checkOutput("rst_done", 32'(song_done), 0);

    reset = 1'b1;
    @(negedge clk);
    $display("[TB] start song 1");
    applyStimulus(1'b1, 1'b0, 2'd1);
    expectNote(1, 0);
    @(negedge clk);
    checkOutput("start_addr", 32'(bus_if.rom_addr), 32);
    checkOutput("start_noload", 32'(bus_if.load_new_note), 0);
    waitLoad(2, "start_load");
    checkOutput("start_note", 32'(bus_if.note_to_load), 1);
    checkOutput("start_dur", 32'(bus_if.duration_to_load), 2);

    expectNote(1, 1);
    pulseDone();
    checkOutput("seq_addr1", 32'(bus_if.rom_addr), 33);
    waitLoad(2, "seq_load1");

    pulseDone();
    checkOutput("seq_addr2", 32'(bus_if.rom_addr), 34);
    @(negedge clk);
    checkOutput("seq_done_early", 32'(song_done), 0);
    @(negedge clk);
    checkOutput("seq_done", 32'(song_done), 1);
    checkOutput("seq_noload", 32'(bus_if.load_new_note), 0);
    bus_if.note_done = 1'b1;
    @(negedge clk);
    bus_if.note_done = 1'b0;
    checkOutput("seq_done_once", 32'(song_done), 0);
    repeat (4) @(negedge clk);
    checkOutput("seq_hold_addr", 32'(bus_if.rom_addr), 34);
    checkOutput("seq_hold_done", 32'(song_done), 0);

    applyStimulus(1'b1, 1'b1, 2'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'd2);
    checkOutput("rs1_addr", 32'(bus_if.rom_addr), 32);

    $display("[TB] full song 2");
    applyStimulus(1'b1, 1'b0, 2'd2);
    expectNote(2, 0);
    @(negedge clk);
    checkOutput("full_addr0", 32'(bus_if.rom_addr), 64);
    waitLoad(2, "full_load0");
    for (int i = 1; i < 32; i++) begin
      expectNote(2, i);
      pulseDone();
      checkOutput("full_addr", 32'(bus_if.rom_addr), 32'(64 + i));
      waitLoad(2, "full_load");
    end
    pulseDone();
    checkOutput("full_done", 32'(song_done), 1);
    checkOutput("full_nowrap", 32'(bus_if.rom_addr), 95);
    @(negedge clk);
    checkOutput("full_done_once", 32'(song_done), 0);
    checkOutput("full_hold_addr", 32'(bus_if.rom_addr), 95);

    applyStimulus(1'b0, 1'b1, 2'd2);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'd0);
    checkOutput("rs2_addr", 32'(bus_if.rom_addr), 64);

    $display("[TB] pause on song 0");
    applyStimulus(1'b1, 1'b0, 2'd0);
    expectNote(0, 0);
    @(negedge clk);
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("pause_noload", 32'(bus_if.load_new_note), 0);
      checkOutput("pause_addr", 32'(bus_if.rom_addr), 0);
    end
    play = 1'b1;
    waitLoad(2, "pause_resume");

    play = 1'b0;
    expectNote(0, 1);
    pulseDone();
    checkOutput("pause_playing_addr", 32'(bus_if.rom_addr), 1);
    play = 1'b1;
    waitLoad(2, "pause_playing_load");

    song = 2'd3;
    for (int i = 2; i <= 5; i++) begin
      expectNote(0, i);
      pulseDone();
      checkOutput("song_ignored_addr", 32'(bus_if.rom_addr), 32'(i));
      waitLoad(2, "idx_load");
    end

    // Restart collides with note_done at idx 5; restart must win.
    restart = 1'b1;
    bus_if.note_done = 1'b1;
    play = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    bus_if.note_done = 1'b0;
    checkOutput("rs3_addr", 32'(bus_if.rom_addr), 0);
    checkOutput("rs3_noload", 32'(bus_if.load_new_note), 0);
    @(negedge clk);
    checkOutput("rs3_idle_addr", 32'(bus_if.rom_addr), 0);

    $display("[TB] song 3 then async reset");
    applyStimulus(1'b1, 1'b0, 2'd3);
    expectNote(3, 0);
    @(negedge clk);
    checkOutput("s3_addr", 32'(bus_if.rom_addr), 96);
    waitLoad(2, "s3_load");

    #2 reset = 1'b0;
    #1;
    checkOutput("arst_addr", 32'(bus_if.rom_addr), 0);
    checkOutput("arst_note", 32'(bus_if.note_to_load), 0);
    checkOutput("arst_dur", 32'(bus_if.duration_to_load), 0);
    checkOutput("arst_load", 32'(bus_if.load_new_note), 0);
    checkOutput("arst_done", 32'(song_done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    expectNote(3, 0);
    @(negedge clk);
    checkOutput("arst_restart_addr", 32'(bus_if.rom_addr), 96);
    waitLoad(2, "arst_restart_load");

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
